// File: rtl/updown_counter_mod.sv
// rtl/updown_counter_mod.sv - parametrised up/down counter with wrap/saturate, step, load, clear and boundary flags
module updown_counter_mod #(
    parameter int          WIDTH     = 8,
    parameter int unsigned MAX_VAL   = (2**WIDTH) - 1,
    parameter int          STEP_W    = 4,
    parameter bit          WRAP_MODE = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_up_down,
    input  logic [STEP_W-1:0] i_step,
    input  logic              i_load,
    input  logic [WIDTH-1:0]  i_load_val,
    input  logic              i_clr,
    output logic [WIDTH-1:0]  o_Q,
    output logic              o_at_max,
    output logic              o_at_min,
    output logic              o_wrap
);

    // One guard bit so sums and differences never silently truncate.
    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0]   MODULUS = MAX_EXT + (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] q;
    logic             wrap;
    logic [WIDTH-1:0] q_next;
    logic             wrap_next;

    logic [WIDTH:0] step_ext;
    logic [WIDTH:0] eff_step;
    logic [WIDTH:0] q_ext;
    logic [WIDTH:0] up_sum;
    logic [WIDTH:0] load_ext;

    always_comb begin
        step_ext = (WIDTH+1)'(i_step);
        eff_step = (step_ext > MAX_EXT) ? MAX_EXT : step_ext;
        q_ext    = {1'b0, q};
        up_sum   = q_ext + eff_step;
        load_ext = {1'b0, i_load_val};

        q_next    = q;
        wrap_next = 1'b0;

        if (i_clr) begin
            q_next = '0;
        end else if (i_load) begin
            q_next = (load_ext > MAX_EXT) ? MAX_Q : i_load_val;
        end else if (i_en) begin
            if (i_up_down) begin
                if (up_sum > MAX_EXT) begin
                    wrap_next = 1'b1;
                    q_next    = WRAP_MODE ? WIDTH'(up_sum - MODULUS) : MAX_Q;
                end else begin
                    q_next = WIDTH'(up_sum);
                end
            end else begin
                if (q_ext < eff_step) begin
                    wrap_next = 1'b1;
                    q_next    = WRAP_MODE ? WIDTH'(q_ext + MODULUS - eff_step) : '0;
                end else begin
                    q_next = WIDTH'(q_ext - eff_step);
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            q    <= '0;
            wrap <= 1'b0;
        end else begin
            q    <= q_next;
            wrap <= wrap_next;
        end
    end

    assign o_Q      = q;
    assign o_wrap   = wrap;
    assign o_at_max = (q == MAX_Q);
    assign o_at_min = (q == '0);

endmodule

// File: doc/updown_counter_mod.md
Name: updown_counter_mod

Overview:
- Parametrised up/down counter; the next generation of the fixed 3-bit up/down counter.
- Adds configurable width and modulus, wrap or saturate mode, variable step, synchronous load and clear, and boundary/event flags.
- Used as a general event/index counter in the datapath and as the RTL-to-GDS flow's reference sequential block.

Parameters:
- WIDTH, 8, counter width in bits (2..32).
- MAX_VAL, 2**WIDTH-1, top count value; modulus = MAX_VAL+1; must be 1..2**WIDTH-1.
- STEP_W, 4, width of the step input (1..WIDTH).
- WRAP_MODE, 1, 1 = wrap modulo MAX_VAL+1; 0 = saturate at 0 / MAX_VAL.

Ports:
- i_clk  input  1  rising-edge clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_en  input  1  count enable.
- i_up_down  input  1  direction: 1 = up, 0 = down.
- i_step  input  STEP_W  increment magnitude per enabled cycle.
- i_load  input  1  synchronous load strobe.
- i_load_val  input  WIDTH  value to load.
- i_clr  input  1  synchronous clear to 0.
- o_Q  output  WIDTH  registered count.
- o_at_max  output  1  o_Q == MAX_VAL (combinational from o_Q).
- o_at_min  output  1  o_Q == 0 (combinational from o_Q).
- o_wrap  output  1  registered one-cycle pulse: previous update wrapped (WRAP_MODE=1) or clipped (WRAP_MODE=0).

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous and active-low on i_rst_n.
- Reset: i_rst_n low forces o_Q=0 and o_wrap=0 immediately, independent of i_clk. Therefore o_at_min=1 and o_at_max=0. Deassertion is synchronised externally.
- Priority on each rising edge: i_clr > i_load > (i_en count) > hold.
- Clear: o_Q <= 0, o_wrap <= 0.
- Load: o_Q <= min(i_load_val, MAX_VAL), o_wrap <= 0. i_en is ignored that cycle.
- Count (i_en=1, no clr/load):
  - eff_step = min(i_step, MAX_VAL). Internal arithmetic is WIDTH+1 bits; there is no silent truncation.
  - Up, no boundary crossed: if o_Q + eff_step <= MAX_VAL, then o_Q <= o_Q + eff_step and o_wrap <= 0.
  - Up, boundary crossed, WRAP_MODE=1: o_Q <= o_Q + eff_step - (MAX_VAL+1), o_wrap <= 1.
  - Up, boundary crossed, WRAP_MODE=0: o_Q <= MAX_VAL, o_wrap <= 1.
  - Down, no boundary crossed: if o_Q >= eff_step, then o_Q <= o_Q - eff_step and o_wrap <= 0.
  - Down, boundary crossed, WRAP_MODE=1: o_Q <= o_Q + (MAX_VAL+1) - eff_step, o_wrap <= 1.
  - Down, boundary crossed, WRAP_MODE=0: o_Q <= 0, o_wrap <= 1.
  - Saturate-mode corner: counting up while already at MAX_VAL with eff_step>0 holds MAX_VAL and pulses o_wrap. Counting down at 0 does the same at 0.
  - eff_step=0: o_Q holds, o_wrap <= 0.
- Hold (i_en=0, no clr/load): o_Q unchanged, o_wrap <= 0.
- Latency: one cycle from an input sample to o_Q / o_wrap; flags follow o_Q in the same cycle.
- Direction change: takes effect on the next enabled edge; no intermediate state.
- Reset mid-operation: reset dominates; state is lost. The first edge after release behaves as from o_Q=0.
- Regression case WIDTH=3, MAX_VAL=7, STEP_W=1, i_step=1, WRAP_MODE=1 (load/clr tied low): reproduces the legacy 3-bit up/down counter sequence.

Test Plan:
- Reset check: WIDTH=4, MAX_VAL=9. Assert i_rst_n=0 mid-cycle -> o_Q=0 immediately, o_at_min=1, o_wrap=0.
- Wrap up (WRAP_MODE=1, MAX_VAL=9): up, step=3 from 0 for 4 cycles -> 3,6,9,2; o_at_max=1 at 9; o_wrap pulses one cycle coincident with o_Q=2.
- Wrap down (WRAP_MODE=1, MAX_VAL=9): load 1, down, step=4 -> 7 with o_wrap=1, then 3 with o_wrap=0.
- Saturate (WRAP_MODE=0, MAX_VAL=9): load 8, up, step=5 -> 9 with o_wrap=1; next edge 9 with o_wrap=1; step=0 -> 9 with o_wrap=0; down, step=15 (eff 9) -> 0.
- Priority and clamp: at o_Q=5, assert i_clr=1, i_load=1, i_en=1 together -> o_Q=0. Next edge i_load=1, i_load_val=14, i_en=1 -> o_Q=9, o_wrap=0.
- Legacy regression (WIDTH=3, MAX_VAL=7, step=1):
  - Stimulus: release reset; up for 5 edges; then down.
  - Required response: 1,2,3,4,5, then 4,3,2,1,0,7,6.
  - o_wrap pulses on the 0->7 step.
